// File: rtl/wb_periph_pkg.sv
// Shared types and defaults for the Wishbone peripheral interconnect.
// Bus widths, default address map and the transaction FSM state encoding.
package wb_periph_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  localparam logic [WB_AW-1:0] DEF_BASE_ADDR   = 32'h3000_0000;
  localparam int               DEF_SLAVE_SHIFT = 16;
  localparam logic [WB_DW-1:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Index field width; a single window still gets one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational window decoder: upper address bits in, hit flag and window index out.
// Only bits at and above SLAVE_SHIFT take part in the decode.
module wb_addr_decode
  import wb_periph_pkg::*;
#(
  parameter int               NUM_SLAVES  = 4,
  parameter logic [WB_AW-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int               SLAVE_SHIFT = DEF_SLAVE_SHIFT,
  parameter int               IW          = idx_width(NUM_SLAVES)
) (
  input  logic [WB_AW-1:SLAVE_SHIFT] adr,
  output logic                       hit,
  output logic [IW-1:0]              idx
);

  localparam logic [IW:0] NS = (IW+1)'(NUM_SLAVES);

  logic base_match;

  assign idx        = adr[SLAVE_SHIFT +: IW];
  assign base_match = (adr[WB_AW-1:SLAVE_SHIFT+IW] == BASE_ADDR[WB_AW-1:SLAVE_SHIFT+IW]);
  // Index slots beyond the populated windows decode as a miss.
  assign hit        = base_match && ({1'b0, idx} < NS);

endmodule

// File: rtl/wb_periph_mux.sv
// Wishbone slave-side interconnect: decodes the management bus into peripheral windows,
// forwards one registered transaction at a time, and answers misses/timeouts with an error.
//
// state | meaning
// IDLE  | waiting for cyc & stb from the master
// BUSY  | request forwarded, waiting for the selected slave ack (timeout counter running)
// ACK   | wbs_ack_o high for this single cycle; no new request accepted
module wb_periph_mux
  import wb_periph_pkg::*;
#(
  parameter int               NUM_SLAVES     = 4,
  parameter logic [WB_AW-1:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter int               SLAVE_SHIFT    = DEF_SLAVE_SHIFT,
  parameter int               TIMEOUT_CYCLES = 255,
  parameter logic [WB_DW-1:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [WB_AW-1:0]            wbs_adr_i,
  input  logic [WB_DW-1:0]            wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [WB_DW-1:0]            wbs_dat_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_sel_o,
  output logic [WB_AW-1:0]            s_adr_o,
  output logic [WB_DW-1:0]            s_dat_o,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES*WB_DW-1:0] s_dat_i,
  input  logic                        err_clr_i,
  output logic                        err_o,
  output logic                        err_irq_o
);

  localparam int            IW       = idx_width(NUM_SLAVES);
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    hit;
  logic [IW-1:0]           req_idx;
  logic                    sel_ack;
  logic [WB_DW-1:0]        sel_dat;
  logic                    err_set;
  logic [NUM_SLAVES-1:0]   cyc_d, stb_d;
  logic                    we_d, ack_d, err_d;
  logic [3:0]              sel_d;
  logic [WB_AW-1:0]        adr_d;
  logic [WB_DW-1:0]        wdat_d, rdat_d;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .SLAVE_SHIFT(SLAVE_SHIFT),
    .IW         (IW)
  ) u_decode (
    .adr(wbs_adr_i[WB_AW-1:SLAVE_SHIFT]),
    .hit(hit),
    .idx(req_idx)
  );

  // Only the selected slave's ack and data are visible; other acks are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IW'(k)) begin
        sel_ack = s_ack_i[k];
        sel_dat = s_dat_i[k*WB_DW +: WB_DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cyc_d   = s_cyc_o;
    stb_d   = s_stb_o;
    we_d    = s_we_o;
    sel_d   = s_sel_o;
    adr_d   = s_adr_o;
    wdat_d  = s_dat_o;
    rdat_d  = wbs_dat_o;
    ack_d   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (hit) begin
            idx_d   = req_idx;
            we_d    = wbs_we_i;
            sel_d   = wbs_sel_i;
            adr_d   = wbs_adr_i;
            wdat_d  = wbs_dat_i;
            cyc_d   = NUM_SLAVES'(1) << req_idx;
            stb_d   = NUM_SLAVES'(1) << req_idx;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            rdat_d  = ERR_DATA;
            ack_d   = 1'b1;
            err_set = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_BUSY: begin
        if (sel_ack) begin
          rdat_d  = sel_dat;
          cyc_d   = '0;
          stb_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (cnt_q == CNT_LAST) begin
          rdat_d  = ERR_DATA;
          cyc_d   = '0;
          stb_d   = '0;
          ack_d   = 1'b1;
          err_set = 1'b1;
          state_d = ST_ACK;
        end else if (!wbs_cyc_i) begin
          cyc_d   = '0;
          stb_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A fresh error outranks a simultaneous clear.
    err_d = err_set | (err_o & ~err_clr_i);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      s_cyc_o   <= '0;
      s_stb_o   <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      err_o     <= 1'b0;
      err_irq_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      s_cyc_o   <= cyc_d;
      s_stb_o   <= stb_d;
      s_we_o    <= we_d;
      s_sel_o   <= sel_d;
      s_adr_o   <= adr_d;
      s_dat_o   <= wdat_d;
      wbs_ack_o <= ack_d;
      wbs_dat_o <= rdat_d;
      err_o     <= err_d;
      err_irq_o <= err_set;
    end
  end

endmodule

// File: tb/tb_wb_periph_mux.sv
// Directed bench for wb_periph_mux with default parameters (4 windows, 255-cycle timeout).
module tb_wb_periph_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         wbs_ack;
  logic [31:0]  wbs_dat;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr, s_dat;
  logic [3:0]   s_ack;
  logic [127:0] s_rdat;
  logic         err_clr, err, err_irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_periph_mux dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack),
    .wbs_dat_o(wbs_dat),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_rdat),
    .err_clr_i(err_clr),
    .err_o    (err),
    .err_irq_o(err_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    sel  = s;
    adr  = a;
    wdat = d;
  endtask

  task automatic release_bus();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    int bad_hold;
    rst_n   = 1'b1;
    cyc     = 1'b0;
    stb     = 1'b0;
    we      = 1'b0;
    sel     = 4'h0;
    adr     = 32'h0;
    wdat    = 32'h0;
    s_ack   = 4'h0;
    s_rdat  = '0;
    err_clr = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ack",  32'(wbs_ack), 32'h0);
    chk("rst_dat",  wbs_dat,      32'h0);
    chk("rst_stb",  32'(s_stb),   32'h0);
    chk("rst_cyc",  32'(s_cyc),   32'h0);
    chk("rst_err",  32'(err),     32'h0);
    chk("rst_sadr", s_adr,        32'h0);
    rst_n = 1'b1;
    tick();

    // Read, slave 1 acks on the first strobe cycle
    req(1'b0, 4'hF, 32'h3001_0004, 32'h0);
    tick();
    chk("rd1_stb", 32'(s_stb),   32'h2);
    chk("rd1_cyc", 32'(s_cyc),   32'h2);
    chk("rd1_adr", s_adr,        32'h3001_0004);
    chk("rd1_we",  32'(s_we),    32'h0);
    chk("rd1_ack_early", 32'(wbs_ack), 32'h0);
    s_ack = 4'b0010;
    s_rdat[63:32] = 32'h1234_5678;
    tick();
    chk("rd1_ack", 32'(wbs_ack), 32'h1);
    chk("rd1_dat", wbs_dat,      32'h1234_5678);
    chk("rd1_stb_off", 32'(s_stb), 32'h0);
    chk("rd1_err", 32'(err),     32'h0);
    s_ack = 4'h0;
    release_bus();
    tick();
    chk("rd1_ack_1cyc", 32'(wbs_ack), 32'h0);
    chk("rd1_dat_hold", wbs_dat,      32'h1234_5678);

    // Write to slave 3, ack after one wait cycle
    req(1'b1, 4'b0011, 32'h3003_0000, 32'hA5A5_0001);
    tick();
    chk("wr_adr", s_adr,        32'h3003_0000);
    chk("wr_dat", s_dat,        32'hA5A5_0001);
    chk("wr_sel", 32'(s_sel),   32'h3);
    chk("wr_we",  32'(s_we),    32'h1);
    chk("wr_stb", 32'(s_stb),   32'h8);
    tick();
    chk("wr_wait_stb", 32'(s_stb),   32'h8);
    chk("wr_wait_ack", 32'(wbs_ack), 32'h0);
    s_ack = 4'b1000;
    tick();
    chk("wr_ack",     32'(wbs_ack), 32'h1);
    chk("wr_stb_off", 32'(s_stb),   32'h0);
    s_ack = 4'h0;
    release_bus();
    tick();
    chk("wr_ack_off", 32'(wbs_ack), 32'h0);

    // Decode miss
    req(1'b0, 4'hF, 32'h3004_0000, 32'h0);
    tick();
    chk("miss_ack", 32'(wbs_ack), 32'h1);
    chk("miss_dat", wbs_dat,      32'hDEAD_BEEF);
    chk("miss_err", 32'(err),     32'h1);
    chk("miss_irq", 32'(err_irq), 32'h1);
    chk("miss_stb", 32'(s_stb),   32'h0);
    release_bus();
    tick();
    chk("miss_ack_off", 32'(wbs_ack), 32'h0);
    chk("miss_irq_off", 32'(err_irq), 32'h0);
    chk("miss_sticky",  32'(err),     32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'h0);

    // Timeout on slave 2
    req(1'b0, 4'hF, 32'h3002_0000, 32'h0);
    tick();
    chk("to_stb", 32'(s_stb), 32'h4);
    bad_hold = 0;
    for (int i = 1; i <= 254; i++) begin
      tick();
      if (wbs_ack !== 1'b0 || s_stb !== 4'b0100) bad_hold++;
    end
    chk("to_hold", 32'(bad_hold), 32'h0);
    tick();
    chk("to_ack", 32'(wbs_ack), 32'h1);
    chk("to_dat", wbs_dat,      32'hDEAD_BEEF);
    chk("to_stb_off", 32'(s_stb), 32'h0);
    chk("to_err", 32'(err),     32'h1);
    chk("to_irq", 32'(err_irq), 32'h1);
    release_bus();
    tick();
    chk("to_ack_off", 32'(wbs_ack), 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err), 32'h0);

    // Ack on the last BUSY cycle beats the timeout
    req(1'b0, 4'hF, 32'h3002_0000, 32'h0);
    tick();
    for (int i = 1; i <= 254; i++) tick();
    chk("late_no_ack", 32'(wbs_ack), 32'h0);
    s_ack = 4'b0100;
    s_rdat[95:64] = 32'hCAFE_F00D;
    tick();
    chk("late_ack", 32'(wbs_ack), 32'h1);
    chk("late_dat", wbs_dat,      32'hCAFE_F00D);
    chk("late_err", 32'(err),     32'h0);
    chk("late_irq", 32'(err_irq), 32'h0);
    s_ack = 4'h0;
    release_bus();
    tick();

    // Foreign ack ignored, then master abort
    req(1'b0, 4'hF, 32'h3002_0008, 32'h0);
    tick();
    chk("ab_stb", 32'(s_stb), 32'h4);
    s_ack = 4'b0001;
    s_rdat[31:0] = 32'h0000_0BAD;
    tick();
    chk("ab_foreign_ack", 32'(wbs_ack), 32'h0);
    chk("ab_foreign_stb", 32'(s_stb),   32'h4);
    s_ack = 4'h0;
    release_bus();
    tick();
    chk("ab_stb_off", 32'(s_stb),   32'h0);
    chk("ab_cyc_off", 32'(s_cyc),   32'h0);
    chk("ab_no_ack",  32'(wbs_ack), 32'h0);
    tick();
    chk("ab_no_ack2", 32'(wbs_ack), 32'h0);
    chk("ab_dat_kept", wbs_dat,     32'hCAFE_F00D);
    // Back in IDLE: a new request is accepted on the very next edge
    req(1'b0, 4'hF, 32'h3001_0000, 32'h0);
    tick();
    chk("ab_idle_accept", 32'(s_stb), 32'h2);

    // Async reset mid-BUSY
    #3 rst_n = 1'b0;
    #1;
    chk("arst_stb", 32'(s_stb),   32'h0);
    chk("arst_cyc", 32'(s_cyc),   32'h0);
    chk("arst_adr", s_adr,        32'h0);
    chk("arst_dat", wbs_dat,      32'h0);
    chk("arst_ack", 32'(wbs_ack), 32'h0);
    release_bus();
    tick();
    chk("arst_hold_ack", 32'(wbs_ack), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("arst_post_ack", 32'(wbs_ack), 32'h0);

    // Fresh read to slave 0 after reset
    req(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    tick();
    chk("post_stb", 32'(s_stb), 32'h1);
    chk("post_adr", s_adr,      32'h3000_0010);
    s_ack = 4'b0001;
    s_rdat[31:0] = 32'h600D_F00D;
    tick();
    chk("post_ack", 32'(wbs_ack), 32'h1);
    chk("post_dat", wbs_dat,      32'h600D_F00D);
    chk("post_err", 32'(err),     32'h0);
    s_ack = 4'h0;
    release_bus();
    tick();
    chk("post_ack_off", 32'(wbs_ack), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_periph_mux.md
Name: wb_periph_mux

Overview:
- Wishbone slave-side interconnect inside the user project macro. Consumes the Caravel management Wishbone bus that the wrapper passes straight through.
- Decodes the address into NUM_SLAVES peripheral windows and forwards a single registered transaction to the selected peripheral.
- Returns the read data and ack to the master. Generates an error response on decode miss or slave timeout, and flags it as a sticky error.

Parameters:
- NUM_SLAVES, 4, number of peripheral windows (1..8).
- BASE_ADDR, 32'h3000_0000, user-space base address.
- SLAVE_SHIFT, 16, log2 of window size (64 KiB windows).
- TIMEOUT_CYCLES, 255, max cycles waiting for a slave ack.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- wb_clk_i  in  1  bus clock; the single clock of the block
- wb_rst_ni  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  master write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  master address
- wbs_dat_i  in  32  master write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- s_cyc_o  out  NUM_SLAVES  one-hot cycle to peripherals
- s_stb_o  out  NUM_SLAVES  one-hot strobe to peripherals
- s_we_o  out  1  registered write enable
- s_sel_o  out  4  registered byte selects
- s_adr_o  out  32  registered address
- s_dat_o  out  32  registered write data
- s_ack_i  in  NUM_SLAVES  peripheral acks
- s_dat_i  in  NUM_SLAVES*32  peripheral read data, slave k at [32k+:32]
- err_clr_i  in  1  clears err_o
- err_o  out  1  sticky error flag (decode miss or timeout)
- err_irq_o  out  1  one-cycle pulse per error; routed to user_irq[0]

Behaviour:
- Reset: wb_rst_ni low asynchronously forces state IDLE, the timeout counter to 0, and every output to 0 (s_* buses, wbs_dat_o, wbs_ack_o, err_o, err_irq_o). This applies mid-transaction too; no ack is issued for an aborted transfer.
- Decode:
  - Hit when wbs_adr_i[31:SLAVE_SHIFT+IW] == BASE_ADDR[31:SLAVE_SHIFT+IW], with IW = clog2(NUM_SLAVES) (minimum 1).
  - Index = wbs_adr_i[SLAVE_SHIFT+:IW].
  - An index >= NUM_SLAVES is a miss.
- FSM states are IDLE, BUSY and ACK.
- IDLE:
  - On an edge with wbs_cyc_i & wbs_stb_i & hit, register we/sel/adr/dat into s_*, set s_cyc_o/s_stb_o bit[index] and clear the counter. Go to BUSY.
  - On the same condition with a miss, load wbs_dat_o=ERR_DATA, set wbs_ack_o, err_o and err_irq_o. Go to ACK.
- BUSY:
  - The counter increments each cycle.
  - If s_ack_i[index] is high: capture s_dat_i[index] into wbs_dat_o (writes also capture, value is don't-care), clear s_cyc_o/s_stb_o, set wbs_ack_o. Go to ACK.
  - Acks from non-selected slaves are ignored.
  - Else if the counter == TIMEOUT_CYCLES-1: clear the strobes, load ERR_DATA, set wbs_ack_o, err_o and err_irq_o. Go to ACK.
  - Else if wbs_cyc_i is low (master abort): clear the strobes. Go to IDLE with no ack.
  - The slave ack has priority over timeout when both occur in the same cycle.
- ACK:
  - wbs_ack_o is high for exactly one cycle.
  - The next edge clears wbs_ack_o. Go to IDLE.
  - A new request is not accepted in this cycle.
  - wbs_dat_o holds its value until the next capture.
- Latency:
  - A hit with a same-cycle slave ack gives wbs_ack_o high 2 cycles after the request edge.
  - A miss gives wbs_ack_o high 1 cycle after the request edge.
  - A timeout gives wbs_ack_o high TIMEOUT_CYCLES+1 cycles after the request edge.
- Sticky error:
  - err_o is sticky until err_clr_i.
  - A new error in the same cycle as err_clr_i wins: err_o stays 1.
- err_irq_o is a registered one-cycle pulse.
- The counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps; it saturates at TIMEOUT_CYCLES-1 before leaving BUSY.

Decomposition:
- Package wb_periph_pkg holds: the state enum (IDLE/BUSY/ACK), the default BASE_ADDR, SLAVE_SHIFT and ERR_DATA, and the Wishbone data/address width constants (32).
- One natural sub-module: wb_addr_decode. It is combinational: address in, hit and index out. It is reused by later bridges.

Test Plan:
- Read to 0x3001_0004 with slave 1 acking on the first s_stb_o cycle returning 0x1234_5678 -> s_stb_o=4'b0010 for 1 cycle; wbs_ack_o one cycle, 2 cycles after the request; wbs_dat_o=0x1234_5678; err_o=0.
- Write 0xA5A5_0001 with sel=4'b0011 to 0x3003_0000 -> s_adr_o=0x3003_0000, s_dat_o=0xA5A5_0001, s_sel_o=4'b0011, s_we_o=1, s_stb_o=4'b1000; ack after slave 3 acks.
- Read to 0x3004_0000 -> no s_stb_o activity; wbs_ack_o 1 cycle after the request; wbs_dat_o=0xDEAD_BEEF; err_o=1; err_irq_o one pulse. Then err_clr_i for 1 cycle -> err_o=0.
- Read to slave 2 with no slave ack -> strobe held 255 cycles then dropped; wbs_ack_o at cycle 256 after the request with 0xDEAD_BEEF; err_o=1. Repeat with the ack arriving on the 255th BUSY cycle -> real data returned, no error.
- Slave 0 acks while slave 2 is selected -> ignored. Then wbs_cyc_i is dropped mid-BUSY -> strobes clear next edge, no wbs_ack_o, state IDLE.
- wb_rst_ni asserted low mid-BUSY, asynchronous to the clock edge -> all outputs 0 immediately. After release, a fresh read to slave 0 completes normally.
